// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light codes, phase enum and per-phase lamp table
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    typedef enum logic [3:0] {
        NS_GREEN,
        NS_YELLOW,
        ALLRED_A,
        EW_GREEN,
        EW_YELLOW,
        ALLRED_B,
        PED_WALK,
        NIGHT_ON,
        NIGHT_OFF
    } phase_t;

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] ew;
        logic       walk;
    } lights_t;

    // Lamp pattern shown for the whole duration of a phase.
    function automatic lights_t phase_lights(phase_t p);
        lights_t l;
        l = '{ns: RED, ew: RED, walk: 1'b0};
        case (p)
            NS_GREEN:  l.ns = GREEN;
            NS_YELLOW: l.ns = YELLOW;
            EW_GREEN:  l.ew = GREEN;
            EW_YELLOW: l.ew = YELLOW;
            PED_WALK:  l.walk = 1'b1;
            NIGHT_ON:  begin l.ns = YELLOW; l.ew = YELLOW; end
            NIGHT_OFF: begin l.ns = OFF;    l.ew = OFF;    end
            default:   l = '{ns: RED, ew: RED, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-TICK_DIV tick generator with synchronous reload
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] TOP = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // Count down to zero; a reload restarts the period so the first tick lands TICK_DIV cycles later.
    always_ff @(posedge clk) begin
        if (rst || reload || cnt == '0) begin
            cnt <= TOP;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - intersection phase sequencer with pedestrian and night modes
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = 4,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 8,
    parameter int BLINK_TICKS  = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic [1:0] light_ns,
    output logic [1:0] light_ew,
    output logic       ped_walk,
    output logic       ped_pending
);

    phase_t         state, state_nx;
    logic [CNT_W-1:0] timer;
    logic           dir_ew, dir_ew_nx;
    logic           tick, expire, quiet, pend_nx;
    lights_t        lt_nx;

    // Timer value loaded on entry: ticks in the phase minus one.
    function automatic logic [CNT_W-1:0] load_of(phase_t p);
        case (p)
            NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_TICKS - 1);
            NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_TICKS - 1);
            PED_WALK:             return CNT_W'(WALK_TICKS - 1);
            NIGHT_ON, NIGHT_OFF:  return CNT_W'(BLINK_TICKS - 1);
            default:              return CNT_W'(ALLRED_TICKS - 1);
        endcase
    endfunction

    // Decision taken when an all-red clearance ends.
    function automatic phase_t resolve(logic night, logic pending, logic to_ew);
        if (night)        return NIGHT_ON;
        else if (pending) return PED_WALK;
        else if (to_ew)   return EW_GREEN;
        else              return NS_GREEN;
    endfunction

    assign expire = tick && (timer == '0);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .reload (expire),
        .tick   (tick)
    );

    // Next phase, remembered crossing direction, pedestrian latch and next lamp pattern.
    always_comb begin
        state_nx  = state;
        dir_ew_nx = dir_ew;
        if (expire) begin
            case (state)
                NS_GREEN:  state_nx = NS_YELLOW;
                NS_YELLOW: state_nx = ALLRED_A;
                ALLRED_A: begin
                    dir_ew_nx = 1'b1;
                    state_nx  = resolve(night_mode, ped_pending | ped_req, 1'b1);
                end
                EW_GREEN:  state_nx = EW_YELLOW;
                EW_YELLOW: state_nx = ALLRED_B;
                ALLRED_B: begin
                    dir_ew_nx = 1'b0;
                    state_nx  = resolve(night_mode, ped_pending | ped_req, 1'b0);
                end
                PED_WALK:  state_nx = dir_ew ? EW_GREEN : NS_GREEN;
                NIGHT_ON:  state_nx = night_mode ? NIGHT_OFF : ALLRED_B;
                NIGHT_OFF: state_nx = night_mode ? NIGHT_ON : ALLRED_B;
                default:   state_nx = ALLRED_B;
            endcase
        end
        quiet = (state == PED_WALK) || (state == NIGHT_ON) || (state == NIGHT_OFF) ||
                (state_nx == PED_WALK) || (state_nx == NIGHT_ON) || (state_nx == NIGHT_OFF);
        pend_nx = quiet ? 1'b0 : (ped_pending | ped_req);
        lt_nx   = phase_lights(state_nx);
    end

    // State and registered outputs move together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ALLRED_B;
            dir_ew      <= 1'b0;
            light_ns    <= RED;
            light_ew    <= RED;
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            dir_ew      <= dir_ew_nx;
            light_ns    <= lt_nx.ns;
            light_ew    <= lt_nx.ew;
            ped_walk    <= lt_nx.walk;
            ped_pending <= pend_nx;
        end
    end

    // Phase timer: reload on entry, count down once per tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= CNT_W'(ALLRED_TICKS - 1);
        end else if (expire) begin
            timer <= load_of(state_nx);
        end else if (tick) begin
            timer <= timer - CNT_W'(1);
        end
    end

endmodule
